btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce_pkg.sv | 25 ++
 rtl/btn_debounce_ch.sv | 149 ++++++++++++++
 rtl/btn_debounce.sv | 49 ++++
 tb/tb_btn_debounce.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pkg
// Shared definitions for the button debouncer: the per-channel FSM state
// encoding, the tick-counter width, and a helper that maps an FSM state to
// the debounced level.
// -----------------------------------------------------------------------------
package btn_debounce_pkg;

  // Width of the per-channel tick counter; holds up to STABLE_TICKS-1 = 14.
  localparam int CNT_W = 4;

  // Bit 1 of the encoding is the debounced level, so PRESSED and
  // RELEASE_WAIT both read as "pressed".
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b11,
    ST_RELEASE_WAIT = 2'b10
  } fsm_state_e;

  function automatic logic is_pressed(input fsm_state_e s);
    return (s == ST_PRESSED) || (s == ST_RELEASE_WAIT);
  endfunction

endpackage : btn_debounce_pkg

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One debounce channel: optional input inversion, 2-flop synchronizer,
// 4-state debounce FSM with tick counter, registered level and edge pulses.
//
// Ports
//   C        in   system clock, rising edge
//   CLR_N    in   asynchronous active-low reset
//   CE       in   sample enable, one C cycle wide
//   BTN      in   raw asynchronous button level
//   STATE    out  debounced level, 1 = pressed (registered)
//   PRESS    out  one-cycle pulse on accepted 0->1
//   RELEASE  out  one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS  = 4,
  parameter bit          IN_ACTIVE_LOW = 1'b0
) (
  input  logic C,
  input  logic CLR_N,
  input  logic CE,
  input  logic BTN,
  output logic STATE,
  output logic PRESS,
  output logic RELEASE
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS);

  logic             btn_in;
  logic             sync1_q;
  logic             sync2_q;
  fsm_state_e       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             stable_done;
  logic             level_now;
  logic             state_q;
  logic             press_q;
  logic             release_q;

  assign btn_in = IN_ACTIVE_LOW ? ~BTN : BTN;

  // Synchronizer runs every clock, independent of CE, so a CE sample always
  // sees a level that has already settled through both flops.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the two synchronizer stages into one.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // The counter never exceeds STABLE_TICKS-1, so this cannot wrap.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign stable_done = (cnt_inc == LAST_CNT);

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      fsm_q <= ST_RELEASED;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: both next-state values get a hold default before any branch, so
  // no path through this block leaves them unassigned (no latch inferred).
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    if (CE) begin
      case (fsm_q)
        ST_RELEASED: begin
          if (sync2_q) begin
            fsm_d = ST_PRESS_WAIT;
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync2_q) begin
            fsm_d = ST_RELEASED;
            cnt_d = '0;
          end else if (stable_done) begin
            fsm_d = ST_PRESSED;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!sync2_q) begin
            fsm_d = ST_RELEASE_WAIT;
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync2_q) begin
            fsm_d = ST_PRESSED;
            cnt_d = '0;
          end else if (stable_done) begin
            fsm_d = ST_RELEASED;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          fsm_d = ST_RELEASED;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Output stage: the level is re-registered every clock, and the pulses
  // compare the new level against the registered one. Reset clears the
  // level register too, so neither reset edge can produce a pulse.
  assign level_now = is_pressed(fsm_q);

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= level_now;
      press_q   <= level_now & ~state_q;
      release_q <= ~level_now & state_q;
    end
  end

  assign STATE   = state_q;
  assign PRESS   = press_q;
  assign RELEASE = release_q;

endmodule : btn_debounce_ch

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Multi-channel push-button debouncer. Each channel is an independent
// btn_debounce_ch instance sharing the clock, reset and sample enable.
//
// Parameters
//   NCH            number of button channels (1..8)
//   STABLE_TICKS   consecutive CE samples needed to accept a change (2..15)
//   IN_ACTIVE_LOW  1 inverts the raw BTN inputs
//
// Ports
//   C        in   system clock, rising edge
//   CLR_N    in   asynchronous active-low reset
//   CE       in   sample enable, one C cycle wide
//   BTN      in   [NCH] raw asynchronous button levels
//   STATE    out  [NCH] debounced levels, 1 = pressed
//   PRESS    out  [NCH] one-cycle pulse on accepted 0->1
//   RELEASE  out  [NCH] one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned NCH           = 2,
  parameter int unsigned STABLE_TICKS  = 4,
  parameter bit          IN_ACTIVE_LOW = 1'b0
) (
  input  logic           C,
  input  logic           CLR_N,
  input  logic           CE,
  input  logic [NCH-1:0] BTN,
  output logic [NCH-1:0] STATE,
  output logic [NCH-1:0] PRESS,
  output logic [NCH-1:0] RELEASE
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS  (STABLE_TICKS),
      .IN_ACTIVE_LOW (IN_ACTIVE_LOW)
    ) u_ch (
      .C       (C),
      .CLR_N   (CLR_N),
      .CE      (CE),
      .BTN     (BTN[g]),
      .STATE   (STATE[g]),
      .PRESS   (PRESS[g]),
      .RELEASE (RELEASE[g])
    );
  end : g_ch

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Directed bench for btn_debounce. Main instance: NCH=2, STABLE_TICKS=4,
// CE every 10 clocks. Second instance: NCH=1, IN_ACTIVE_LOW=1, CE tied high.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

  logic       c;
  logic       clr_n;
  logic       ce;
  logic [1:0] btn;
  logic [1:0] state;
  logic [1:0] press;
  logic [1:0] rls;

  logic [0:0] btn_al;
  logic [0:0] state_al;
  logic [0:0] press_al;
  logic [0:0] rls_al;

  int n_checks;
  int n_errors;
  int n_press [2];
  int n_rel   [2];
  int n_press_al;

  btn_debounce #(
    .NCH           (2),
    .STABLE_TICKS  (4),
    .IN_ACTIVE_LOW (1'b0)
  ) dut (
    .C       (c),
    .CLR_N   (clr_n),
    .CE      (ce),
    .BTN     (btn),
    .STATE   (state),
    .PRESS   (press),
    .RELEASE (rls)
  );

  btn_debounce #(
    .NCH           (1),
    .STABLE_TICKS  (4),
    .IN_ACTIVE_LOW (1'b1)
  ) dut_al (
    .C       (c),
    .CLR_N   (clr_n),
    .CE      (1'b1),
    .BTN     (btn_al),
    .STATE   (state_al),
    .PRESS   (press_al),
    .RELEASE (rls_al)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge c);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_press[i] += int'(press[i]);
      n_rel[i]   += int'(rls[i]);
    end
    n_press_al += int'(press_al);
  endtask

  // n CE samples: 9 idle clocks then one clock with CE high. Returns just
  // after the edge on which the FSM consumed the sample.
  task automatic ce_sample(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (9) step();
      ce = 1'b1;
      step();
      ce = 1'b0;
    end
  endtask

  task automatic clear_counts();
    n_press    = '{0, 0};
    n_rel      = '{0, 0};
    n_press_al = 0;
  endtask

  int first_al;

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_counts();
    clr_n  = 1'b0;
    ce     = 1'b0;
    btn    = 2'b00;
    btn_al = 1'b1;     // active-low input: 1 = released

    // Reset state
    #1;
    check("rst_state", int'(state), 0);
    check("rst_press", int'(press), 0);
    check("rst_release", int'(rls), 0);
    check("rst_state_al", int'(state_al), 0);
    repeat (3) step();
    clr_n = 1'b1;
    repeat (3) step();
    check("rst_deassert_quiet", int'(press) + int'(rls) + int'(state), 0);
    clear_counts();

    // Clean press on channel 0
    btn = 2'b01;
    ce_sample(3);
    check("press_3_samples_state", int'(state), 0);
    check("press_3_samples_cnt", int'(dut.g_ch[0].u_ch.cnt_q), 3);
    ce_sample(1);
    check("press_accept_edge_state", int'(state), 0);
    step();
    check("press_state", int'(state), 1);
    check("press_pulse", int'(press), 1);
    step();
    check("press_pulse_end", int'(press), 0);
    ce_sample(2);
    check("press_count0", n_press[0], 1);
    check("ch1_quiet", n_press[1] + n_rel[1] + int'(state[1]), 0);

    // Bouncing release: low 2, high 1, low 4
    btn = 2'b00;
    ce_sample(2);
    check("bounce_low2_state", int'(state), 1);
    btn = 2'b01;
    ce_sample(1);
    btn = 2'b00;
    ce_sample(3);
    check("bounce_no_early_release", n_rel[0], 0);
    check("bounce_state_held", int'(state), 1);
    ce_sample(1);
    step();
    check("bounce_release_pulse", int'(rls), 1);
    check("bounce_state_low", int'(state), 0);
    ce_sample(1);
    check("bounce_release_count", n_rel[0], 1);
    check("bounce_no_extra_press", n_press[0], 1);

    // Short glitch: 3 samples high, then low
    btn = 2'b01;
    ce_sample(3);
    btn = 2'b00;
    ce_sample(1);
    check("glitch_cnt_cleared", int'(dut.g_ch[0].u_ch.cnt_q), 0);
    check("glitch_state", int'(state), 0);
    ce_sample(1);
    check("glitch_no_press", n_press[0], 1);

    // Both channels in the same cycle, then independent release of ch 0
    btn = 2'b11;
    ce_sample(4);
    step();
    check("both_press", int'(press), 3);
    check("both_state", int'(state), 3);
    btn = 2'b10;
    ce_sample(4);
    step();
    check("ch0_only_release", int'(rls), 1);
    check("ch0_only_state", int'(state), 2);

    // Reset mid-debounce with both buttons held
    btn = 2'b11;
    ce_sample(2);
    check("mid_cnt", int'(dut.g_ch[0].u_ch.cnt_q), 2);
    #2;
    clr_n = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_pulses", int'(press) + int'(rls), 0);
    check("async_rst_cnt", int'(dut.g_ch[0].u_ch.cnt_q), 0);
    clear_counts();
    repeat (3) step();
    clr_n = 1'b1;
    ce_sample(3);
    check("post_rst_3_state", int'(state), 0);
    check("post_rst_no_pulse", n_press[0] + n_press[1] + n_rel[0] + n_rel[1], 0);
    ce_sample(1);
    step();
    check("post_rst_press", int'(press), 3);
    btn = 2'b00;

    // Active-low instance, CE tied high: press 7 clocks after the edge
    clear_counts();
    first_al = 0;
    btn_al = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (press_al[0] && first_al == 0) first_al = k;
    end
    check("al_latency", first_al, 7);
    check("al_single_pulse", n_press_al, 1);
    check("al_state", int'(state_al), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_btn_debounce
